// File: rtl/uart_rx_if.sv
// ============================================================================
// Module : uart_rx_if
// Brief  : Serial line plus received-byte valid/ready handshake for uart_rx.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_rx_if;
  logic       uart_rx;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  // master: the receiver, which produces bytes; slave: the line driver and byte consumer
  modport master (
    input  uart_rx, data_ready,
    output data, data_valid, busy, frame_err, overrun
  );

  modport slave (
    output uart_rx, data_ready,
    input  data, data_valid, busy, frame_err, overrun
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module : uart_rx
// Brief  : 8N1 UART receiver, mid-bit sampling, valid/ready byte output with
//          framing-error and overrun pulses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter logic [31:0] FMAX_MHz = 32'd27,
  parameter logic [31:0] BaudRate = 32'd115200
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  uart_rx_if.master    bus
);

  localparam logic [31:0] DELAY_FRAMES = (FMAX_MHz * 32'd1000000) / BaudRate;
  localparam logic [31:0] HALF_FRAMES  = DELAY_FRAMES / 32'd2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        s1_q, s2_q;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;

  logic        rxs;
  logic        accept;
  logic        end_half;
  logic        end_full;

  assign rxs      = s2_q;
  assign accept   = valid_q & bus.data_ready;
  assign end_half = (cnt_q + 32'd1) == HALF_FRAMES;
  assign end_full = (cnt_q + 32'd1) == DELAY_FRAMES;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      s1_q    <= bus.uart_rx;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (accept) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = 32'd0;
        if (!rxs) begin
          state_d = START;
        end
      end
      START: begin
        if (end_half) begin
          cnt_d = 32'd0;
          if (!rxs) begin
            state_d = DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DATA: begin
        if (end_full) begin
          cnt_d          = 32'd0;
          shift_d[idx_q] = rxs;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      STOP: begin
        if (end_full) begin
          cnt_d = 32'd0;
          if (rxs) begin
            state_d = IDLE;
            // A same-edge accept frees the holding register for the new byte
            if (!valid_q || accept) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WAIT_HIGH: begin
        cnt_d = 32'd0;
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 32'd0;
      end
    endcase
  end

  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module : tb_uart_rx
// Brief  : Directed self-checking bench for uart_rx at 27 MHz / 115200 baud.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int BIT = 234;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(
    .FMAX_MHz (32'd27),
    .BaudRate (32'd115200)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run = 0;
  int fails     = 0;

  int         ferr_n = 0;
  int         ovr_n  = 0;
  int         vcyc_n = 0;
  int         both_n = 0;
  logic [7:0] acc_q[$];

  // Observed half a cycle after each active edge; inputs are settled for the next edge
  always begin
    @(negedge clk);
    #1;
    if (rst_n === 1'b1) begin
      if (bus.frame_err) ferr_n++;
      if (bus.overrun) ovr_n++;
      if (bus.frame_err && bus.overrun) both_n++;
      if (bus.data_valid) vcyc_n++;
      if (bus.data_valid && bus.data_ready) acc_q.push_back(bus.data);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    bus.uart_rx = 1'b0;
    clks(BIT);
    for (int i = 0; i < nbits; i++) begin
      bus.uart_rx = b[i];
      clks(BIT);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb);
    send_bits(b, 8);
    bus.uart_rx = stopb;
    clks(BIT);
  endtask

  task automatic test_reset;
    rst_n          = 1'b0;
    bus.uart_rx    = 1'b1;
    bus.data_ready = 1'b0;
    clks(3);
    tests_run++; if (bus.data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h exp 00", bus.data); end
    tests_run++; if (bus.data_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b exp 0", bus.data_valid); end
    tests_run++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
    tests_run++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b exp 0", bus.frame_err); end
    tests_run++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL reset_ovr: got %b exp 0", bus.overrun); end
    rst_n = 1'b1;
    clks(5);
  endtask

  task automatic test_basic;
    int n;
    int f0, o0;
    f0 = ferr_n; o0 = ovr_n;
    bus.data_ready = 1'b0;
    n = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (bus.data_valid !== 1'b1 && n < 3000) begin
          @(posedge clk); #1; n++;
        end
      end
    join
    // 2 sync + 1 IDLE detect edge, then HALF + 9*DELAY to the stop sample
    tests_run++; if (n != 2226) begin fails++; $display("FAIL basic_latency: got %0d edges exp 2226", n); end
    tests_run++; if (bus.data !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h exp a5", bus.data); end
    clks(20);
    tests_run++; if (bus.data_valid !== 1'b1) begin fails++; $display("FAIL basic_hold: got %b exp 1", bus.data_valid); end
    bus.data_ready = 1'b1;
    clks(1);
    bus.data_ready = 1'b0;
    tests_run++; if (bus.data_valid !== 1'b0) begin fails++; $display("FAIL basic_accept: got %b exp 0", bus.data_valid); end
    tests_run++; if (ferr_n != f0 || ovr_n != o0) begin fails++; $display("FAIL basic_flags: got ferr %0d ovr %0d exp 0 0", ferr_n - f0, ovr_n - o0); end
  endtask

  task automatic test_back_to_back;
    int s, v0, f0, o0;
    s = acc_q.size(); v0 = vcyc_n; f0 = ferr_n; o0 = ovr_n;
    bus.data_ready = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    clks(BIT);
    tests_run++;
    if (acc_q.size() != s + 2) begin
      fails++; $display("FAIL b2b_count: got %0d bytes exp 2", acc_q.size() - s);
    end else begin
      tests_run++; if (acc_q[s] !== 8'h00) begin fails++; $display("FAIL b2b_first: got %h exp 00", acc_q[s]); end
      tests_run++; if (acc_q[s+1] !== 8'hFF) begin fails++; $display("FAIL b2b_second: got %h exp ff", acc_q[s+1]); end
    end
    tests_run++; if (vcyc_n - v0 != 2) begin fails++; $display("FAIL b2b_valid_cycles: got %0d exp 2", vcyc_n - v0); end
    tests_run++; if (ferr_n != f0 || ovr_n != o0) begin fails++; $display("FAIL b2b_flags: got ferr %0d ovr %0d exp 0 0", ferr_n - f0, ovr_n - o0); end
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = vcyc_n; f0 = ferr_n;
    bus.data_ready = 1'b0;
    bus.uart_rx    = 1'b0;
    clks(30);
    tests_run++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_start: got %b exp 1", bus.busy); end
    clks(20);
    bus.uart_rx = 1'b1;
    clks(200);
    tests_run++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_end: got %b exp 0", bus.busy); end
    tests_run++; if (vcyc_n != v0 || ferr_n != f0) begin fails++; $display("FAIL glitch_outputs: got valid %0d ferr %0d exp 0 0", vcyc_n - v0, ferr_n - f0); end
  endtask

  task automatic test_frame_err;
    int v0, f0, s;
    v0 = vcyc_n; f0 = ferr_n;
    bus.data_ready = 1'b1;
    send_frame(8'h3C, 1'b0);
    clks(1000);
    tests_run++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL ferr_busy_break: got %b exp 1", bus.busy); end
    tests_run++; if (ferr_n - f0 != 1) begin fails++; $display("FAIL ferr_pulse: got %0d exp 1", ferr_n - f0); end
    tests_run++; if (vcyc_n != v0) begin fails++; $display("FAIL ferr_novalid: got %0d exp 0", vcyc_n - v0); end
    bus.uart_rx = 1'b1;
    clks(10);
    tests_run++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ferr_busy_release: got %b exp 0", bus.busy); end
    s = acc_q.size();
    send_frame(8'h5A, 1'b1);
    clks(BIT);
    tests_run++;
    if (acc_q.size() != s + 1) begin
      fails++; $display("FAIL ferr_next_count: got %0d exp 1", acc_q.size() - s);
    end else if (acc_q[s] !== 8'h5A) begin
      fails++; $display("FAIL ferr_next_data: got %h exp 5a", acc_q[s]);
    end
  endtask

  task automatic test_overrun;
    int o0, s;
    o0 = ovr_n;
    bus.data_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    clks(20);
    tests_run++; if (ovr_n - o0 != 1) begin fails++; $display("FAIL ovr_pulse: got %0d exp 1", ovr_n - o0); end
    tests_run++; if (bus.data !== 8'h11) begin fails++; $display("FAIL ovr_data_kept: got %h exp 11", bus.data); end
    tests_run++; if (bus.data_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid_kept: got %b exp 1", bus.data_valid); end
    bus.data_ready = 1'b1;
    clks(1);
    bus.data_ready = 1'b0;

    send_frame(8'h11, 1'b1);
    clks(20);
    o0 = ovr_n; s = acc_q.size();
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (2225) @(posedge clk);
        @(negedge clk);
        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
      end
    join
    tests_run++; if (bus.data !== 8'h22) begin fails++; $display("FAIL coincide_data: got %h exp 22", bus.data); end
    tests_run++; if (bus.data_valid !== 1'b1) begin fails++; $display("FAIL coincide_valid: got %b exp 1", bus.data_valid); end
    tests_run++; if (ovr_n != o0) begin fails++; $display("FAIL coincide_ovr: got %0d exp 0", ovr_n - o0); end
    tests_run++;
    if (acc_q.size() != s + 1) begin
      fails++; $display("FAIL coincide_accept_count: got %0d exp 1", acc_q.size() - s);
    end else if (acc_q[s] !== 8'h11) begin
      fails++; $display("FAIL coincide_accept_data: got %h exp 11", acc_q[s]);
    end
    bus.data_ready = 1'b1;
    clks(1);
    bus.data_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int f0, o0, s;
    bus.data_ready = 1'b0;
    send_frame(8'h81, 1'b1);
    clks(5);
    tests_run++; if (bus.data_valid !== 1'b1) begin fails++; $display("FAIL rstmid_pre_valid: got %b exp 1", bus.data_valid); end
    send_bits(8'hC3, 4);
    bus.uart_rx = 1'b0;
    clks(100);
    rst_n = 1'b0;
    #1;
    tests_run++; if (bus.data !== 8'h00) begin fails++; $display("FAIL rstmid_data: got %h exp 00", bus.data); end
    tests_run++; if (bus.data_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b exp 0", bus.data_valid); end
    tests_run++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b exp 0", bus.busy); end
    clks(5);
    bus.uart_rx = 1'b1;
    rst_n       = 1'b1;
    clks(300);
    f0 = ferr_n; o0 = ovr_n; s = acc_q.size();
    bus.data_ready = 1'b1;
    send_frame(8'hC3, 1'b1);
    clks(BIT);
    tests_run++;
    if (acc_q.size() != s + 1) begin
      fails++; $display("FAIL rstmid_next_count: got %0d exp 1", acc_q.size() - s);
    end else if (acc_q[s] !== 8'hC3) begin
      fails++; $display("FAIL rstmid_next_data: got %h exp c3", acc_q[s]);
    end
    tests_run++; if (ferr_n != f0 || ovr_n != o0) begin fails++; $display("FAIL rstmid_flags: got ferr %0d ovr %0d exp 0 0", ferr_n - f0, ovr_n - o0); end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.uart_rx    = 1'b1;
    bus.data_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    tests_run++; if (both_n != 0) begin fails++; $display("FAIL flags_exclusive: got %0d exp 0", both_n); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

`default_nettype wire
